// File: rtl/demux_1x8_sched.sv
// demux_1x8_sched: round-robin scheduler driving a 1-to-8 demux.
// One sink is granted at a time for up to BURST registered beats.
module demux_1x8_sched #(
    parameter int DW    = 1,
    parameter int BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] i,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [7:0]    req,
    output logic          s,
    output logic          s1,
    output logic          s2,
    output logic          en,
    output logic [DW-1:0] o,
    output logic [7:0]    gnt,
    output logic [7:0]    ack
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER
    } state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [2:0] sel;
    logic [2:0] pick;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic       found;
    logic       sel_req;
    logic       last;

    assign sel     = {s2, s1, s};
    assign sel_req = req[sel];
    assign i_ready = (state == XFER) && sel_req;
    assign last    = (cnt + 4'd1) == 4'(BURST);

    // Round-robin search starting just past the last served sink
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Arbitration, grant lifetime and beat forwarding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd7;
            cnt       <= '0;
            {s2, s1, s} <= '0;
            en        <= 1'b0;
            gnt       <= '0;
            ack       <= '0;
            o         <= '0;
        end else begin
            ack <= '0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        {s2, s1, s} <= pick;
                        en    <= 1'b1;
                        gnt   <= 8'd1 << pick;
                        cnt   <= '0;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (sel_req) begin
                        state <= XFER;
                    end else begin
                        state <= IDLE;
                        en    <= 1'b0;
                        gnt   <= '0;
                    end
                end
                XFER: begin
                    if (!sel_req) begin
                        state <= IDLE;
                        en    <= 1'b0;
                        gnt   <= '0;
                        if (cnt != 4'd0) ptr <= sel;
                    end else if (i_valid) begin
                        o   <= i;
                        ack <= 8'd1 << sel;
                        cnt <= cnt + 4'd1;
                        if (last) begin
                            state <= IDLE;
                            ptr   <= sel;
                            en    <= 1'b0;
                            gnt   <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/demux_1x8_sched.md
DEMUX_1X8_SCHED -- requirements
Module: demux_1x8_sched

Interface
REQ-001 The block SHALL have parameter DW, default 1, giving the width of the source data word.
REQ-002 The block SHALL have parameter BURST, default 4, giving the maximum beats per grant; the legal range is 1..15.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port i  input  DW  source data word.
REQ-006 The block SHALL have port i_valid  input  1  source offers i this cycle.
REQ-007 The block SHALL have port i_ready  output  1  the block accepts i this cycle.
REQ-008 The block SHALL have port req  input  8  per-sink request; bit k means sink k wants data.
REQ-009 The block SHALL have ports s, s1, s2  output  1 each  demux select, with s as the LSB; sink index = {s2,s1,s}.
REQ-010 The block SHALL have port en  output  1  demux enable; high while a grant is active.
REQ-011 The block SHALL have port o  output  DW  registered data forwarded to the selected sink.
REQ-012 The block SHALL have port gnt  output  8  one-hot grant, equal to 1<<{s2,s1,s} while en=1, otherwise 0.
REQ-013 The block SHALL have port ack  output  8  one-hot, one-cycle strobe marking o as valid for sink {s2,s1,s}.

Function
REQ-014 The block SHALL implement the states IDLE, SETUP and XFER, plus a 3-bit round-robin pointer ptr and a 4-bit beat counter cnt.
REQ-015 In IDLE with req!=0, the block SHALL pick the first set req bit searching ptr+1, ptr+2, ... modulo 8, so that index 7 wraps to 0.
REQ-016 On that pick, the block SHALL load {s2,s1,s} with the winner, set en=1 and gnt, clear cnt, and go to SETUP, all on the next edge.
REQ-017 In IDLE with req==0, the block SHALL stay in IDLE with en=0 and gnt=0, while s/s1/s2 hold their last value.
REQ-018 SETUP SHALL last exactly one cycle (select settle) with i_ready=0; the block SHALL then go to XFER if req[sel]=1, otherwise to IDLE with ptr unchanged.
REQ-019 In XFER, the block SHALL drive i_ready combinationally as req[sel], and as 0 in all other states.
REQ-020 A beat SHALL occur when i_valid & i_ready; on the following edge, o<=i, ack<=1<<sel for exactly one cycle, and cnt<=cnt+1.
REQ-021 When a beat makes cnt reach BURST, the block SHALL go to IDLE, set ptr<=sel, and clear en and gnt on the same edge.
REQ-022 If req[sel] is 0 in XFER, the block SHALL end the grant on the next edge with no beat, go to IDLE, and set ptr<=sel if cnt>0, otherwise leave ptr unchanged.
REQ-023 If i_valid=0 in XFER and req[sel]=1, the block SHALL hold the state, grant and cnt with no timeout.
REQ-024 When a grant ends, the block SHALL always spend at least one IDLE cycle before the next SETUP, even if req is still nonzero.
REQ-025 Changes on req bits other than sel during SETUP/XFER SHALL have no effect until the next IDLE arbitration.
REQ-026 The block SHALL change s, s1 and s2 only on the IDLE->SETUP edge, keeping them stable for the whole grant.
REQ-027 o SHALL hold its value between beats, and ack SHALL be 0 on every cycle without a preceding beat.
REQ-028 Request-to-first-data latency SHALL be: req at cycle N -> SETUP at N+1 -> i_ready at N+2 -> ack/o at N+3 if i_valid was high at N+2.

Reset
REQ-029 While rst_n=0, regardless of the clock, the block SHALL hold state=IDLE, ptr=7, cnt=0, s=s1=s2=0, en=0, gnt=0, ack=0, o=0 and i_ready=0.
REQ-030 When rst_n asserts mid-burst, the block SHALL abort the transfer immediately; the partly served sink gets no further ack, and after release arbitration restarts from index 0.
REQ-031 After rst_n deasserts, the block SHALL perform its first arbitration on the first rising edge with req!=0.

Verification
REQ-032 The bench SHALL check: after reset, req=8'h01 and i_valid=1 with i stepping 1,0,1,1 -> gnt=8'h01, sel=0, ack[0] for 4 consecutive cycles starting at N+3, o=1,0,1,1, then en=0.
REQ-033 The bench SHALL check: req=8'hFF held constant -> grants in order 0,1,...,7,0, each of BURST beats with one IDLE cycle between grants, and the 7->0 wrap is checked.
REQ-034 The bench SHALL check: req=8'h90 after ptr=4 -> sink 7 granted first ({s2,s1,s}=111), then sink 4.
REQ-035 The bench SHALL check: the granted sink drops req after 2 beats -> the grant ends with cnt=2, ptr=sel, and no further ack.
REQ-036 The bench SHALL check: req drops during SETUP -> IDLE next cycle, no ack, ptr unchanged, and the same sink wins again on re-request.
REQ-037 The bench SHALL check: i_valid=0 for 5 cycles in XFER -> hold with en=1 and no ack; then rst_n pulsed low mid-burst -> all outputs 0 asynchronously and ptr=7.
